// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined 4x4 multiplier among NREQ requesters.
// Optional MULT_SHARE_ARB_STATS_EN adds op_count/stall_count statistics outputs.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_x,
    input  logic [4*NREQ-1:0]   req_y,
    input  logic                hold,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [7:0]          rsp_z,
    output logic                busy,
    output logic [3:0]          mul_x,
    output logic [3:0]          mul_y,
    output logic                mul_enable,
`ifdef MULT_SHARE_ARB_STATS_EN
    output logic [15:0]         op_count,
    output logic [15:0]         stall_count,
`endif
    input  logic [7:0]          mul_z
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [LAT-1:0]  tag_v_r;
    logic [PW-1:0]   tag_id_r [LAT];

    logic            issue_s;
    logic [PW-1:0]   sel_s;
    logic            pending_s;
    logic [3:0]      xa_s [NREQ];
    logic [3:0]      ya_s [NREQ];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (int'(p) == NREQ - 1) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign xa_s[g] = req_x[4*g +: 4];
        assign ya_s[g] = req_y[4*g +: 4];
    end

    // Round-robin search from the pointer; the grant is combinational so the issue lands in the request cycle.
    always_comb begin
        logic [PW-1:0] idx_s;
        issue_s = 1'b0;
        sel_s   = '0;
        idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = PW'((int'(ptr_r) + k) % NREQ);
            if (!issue_s && req[idx_s]) begin
                issue_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                issue_s = issue_s;
            end
        end
        if (hold || !reset) begin
            issue_s = 1'b0;
        end else begin
            issue_s = issue_s;
        end
    end

    // Grant pulse and operand steering to the multiplier.
    always_comb begin
        gnt   = '0;
        mul_x = 4'd0;
        mul_y = 4'd0;
        if (issue_s) begin
            gnt[sel_s] = 1'b1;
            mul_x      = xa_s[sel_s];
            mul_y      = ya_s[sel_s];
        end else begin
            gnt = '0;
        end
    end

    // Products still travelling inside the multiplier need its enable to keep loading.
    always_comb begin
        pending_s = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            pending_s = pending_s | tag_v_r[k];
        end
    end

    assign mul_enable = issue_s | pending_s;
    assign busy       = (state_r != ST_IDLE);

    // Response routing from the last tag stage.
    always_comb begin
        rsp_valid = '0;
        rsp_z     = 8'd0;
        if (tag_v_r[LAT-1]) begin
            rsp_valid[tag_id_r[LAT-1]] = 1'b1;
            rsp_z                      = mul_z;
        end else begin
            rsp_z = 8'd0;
        end
    end

    // FSM, round-robin pointer and tag pipeline.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            tag_v_r <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_v_r[0]  <= issue_s;
            tag_id_r[0] <= sel_s;
            for (int k = 1; k < LAT; k++) begin
                tag_v_r[k]  <= tag_v_r[k-1];
                tag_id_r[k] <= tag_id_r[k-1];
            end
            if (issue_s) begin
                ptr_r <= wrap_inc(sel_s);
            end else begin
                ptr_r <= ptr_r;
            end
            case (state_r)
                ST_IDLE:  state_r <= issue_s ? ST_RUN : ST_IDLE;
                ST_RUN,
                ST_DRAIN: state_r <= issue_s ? ST_RUN : (pending_s ? ST_DRAIN : ST_IDLE);
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef MULT_SHARE_ARB_STATS_EN
    // Saturating grant and stall counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_count    <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (issue_s && (op_count != 16'hFFFF)) begin
                op_count <= op_count + 16'd1;
            end else begin
                op_count <= op_count;
            end
            if ((|req) && !issue_s && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end else begin
                stall_count <= stall_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter with a behavioural 2-stage multiplier.
module tb_mult_share_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] req_x = 16'd0;
    logic [15:0] req_y = 16'd0;
    logic        hold = 1'b0;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_z;
    logic        busy;
    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic        mul_enable;
    logic [7:0]  mul_z = 8'd0;
    logic [7:0]  pp_r = 8'd0;
`ifdef MULT_SHARE_ARB_STATS_EN
    logic [15:0] op_count;
    logic [15:0] stall_count;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] v;
        logic [7:0] z;
    } exp_t;

    exp_t sbq[$];
    int   cnt = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clock = ~clock;

    mult_share_arbiter #(.NREQ(4), .LAT(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .hold       (hold),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_z      (rsp_z),
        .busy       (busy),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_enable (mul_enable),
`ifdef MULT_SHARE_ARB_STATS_EN
        .op_count   (op_count),
        .stall_count(stall_count),
`endif
        .mul_z      (mul_z)
    );

    // Shared multiplier: enable-gated partial-product and output registers.
    always @(posedge clock) begin
        if (mul_enable) begin
            pp_r  <= {4'd0, mul_x} * {4'd0, mul_y};
            mul_z <= pp_r;
        end
    end

    always @(posedge clock) cnt <= cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0; req = 4'hF; req_x = 16'hFFFF; req_y = 16'hFFFF; hold = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_mul_enable", mul_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_mul_x", mul_x, 0);
        chk("rst_mul_y", mul_y, 0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1; req = 4'd0; req_x = 16'd0; req_y = 16'd0;
    endtask

    // One cycle of stimulus; expected grant/enable/busy checked mid-cycle, products queued for the monitor.
    task automatic cyc(input logic [3:0] r, input logic [15:0] xs, input logic [15:0] ys,
                       input logic h, input logic [3:0] eg, input logic [7:0] ez,
                       input logic ee, input logic eb);
        logic [3:0] ex;
        logic [3:0] ey;
        exp_t       e;
        ex = 4'd0;
        ey = 4'd0;
        @(posedge clock); #1;
        req = r; req_x = xs; req_y = ys; hold = h;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                ex = xs[4*i +: 4];
                ey = ys[4*i +: 4];
            end
        end
        chk("gnt", gnt, eg);
        chk("mul_enable", mul_enable, ee);
        chk("busy", busy, eb);
        chk("mul_x", mul_x, ex);
        chk("mul_y", mul_y, ey);
        if (eg != 4'd0) begin
            e.cyc = cnt + 2;
            e.v   = eg;
            e.z   = ez;
            sbq.push_back(e);
        end
    endtask

    initial begin
        fork
            forever begin
                exp_t m;
                @(negedge clock);
                if (sbq.size() > 0 && sbq[0].cyc < cnt) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL missing_rsp: got none, want rsp_valid=%b rsp_z=%0d at cycle %0d",
                             sbq[0].v, sbq[0].z, sbq[0].cyc);
                    void'(sbq.pop_front());
                end
                if (rsp_valid != 4'd0) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_rsp: got rsp_valid=%b rsp_z=%0d, want none (cycle %0d)",
                                 rsp_valid, rsp_z, cnt);
                    end else begin
                        m = sbq.pop_front();
                        chk("rsp_cycle", cnt, m.cyc);
                        chk("rsp_valid", rsp_valid, m.v);
                        chk("rsp_z", rsp_z, m.z);
                    end
                end else begin
                    chk("rsp_z_idle", rsp_z, 0);
                end
            end
        join_none

        // Single request: 3*5.
        do_reset();
        cyc(4'b0001, 16'h0003, 16'h0005, 1'b0, 4'b0001, 8'd15, 1'b1, 1'b0);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,  1'b1, 1'b1);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,  1'b0, 1'b1);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,  1'b0, 1'b0);

        // All four requesting: (15,15),(2,7),(9,4),(1,1).
        do_reset();
        cyc(4'hF, 16'h192F, 16'h147F, 1'b0, 4'b0001, 8'd225, 1'b1, 1'b0);
        cyc(4'hF, 16'h192F, 16'h147F, 1'b0, 4'b0010, 8'd14,  1'b1, 1'b1);
        cyc(4'hF, 16'h192F, 16'h147F, 1'b0, 4'b0100, 8'd36,  1'b1, 1'b1);
        cyc(4'hF, 16'h192F, 16'h147F, 1'b0, 4'b1000, 8'd1,   1'b1, 1'b1);
        cyc(4'hF, 16'h192F, 16'h147F, 1'b0, 4'b0001, 8'd225, 1'b1, 1'b1);
        cyc(4'h0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,   1'b1, 1'b1);
        cyc(4'h0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,   1'b0, 1'b1);
        cyc(4'h0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,   1'b0, 1'b0);

        // Fairness: one grant to 0 moves the pointer to 1, then 0 and 2 alternate starting with 2.
        do_reset();
        cyc(4'b0001, 16'h0502, 16'h0603, 1'b0, 4'b0001, 8'd6, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(4'b0101, 16'h0502, 16'h0603, 1'b0,
                (i % 2 == 0) ? 4'b0100 : 4'b0001, (i % 2 == 0) ? 8'd30 : 8'd6, 1'b1, 1'b1);
        end
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b1);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b1);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);

        // Hold: requester 1 streams 7*3, hold for three cycles, then resume.
        do_reset();
        cyc(4'b0010, 16'h0070, 16'h0030, 1'b0, 4'b0010, 8'd21, 1'b1, 1'b0);
        cyc(4'b0010, 16'h0070, 16'h0030, 1'b0, 4'b0010, 8'd21, 1'b1, 1'b1);
        cyc(4'b0010, 16'h0070, 16'h0030, 1'b0, 4'b0010, 8'd21, 1'b1, 1'b1);
        cyc(4'b0010, 16'h0070, 16'h0030, 1'b1, 4'b0000, 8'd0,  1'b1, 1'b1);
        cyc(4'b0010, 16'h0070, 16'h0030, 1'b1, 4'b0000, 8'd0,  1'b0, 1'b1);
        cyc(4'b0010, 16'h0070, 16'h0030, 1'b1, 4'b0000, 8'd0,  1'b0, 1'b0);
        cyc(4'b0010, 16'h0070, 16'h0030, 1'b0, 4'b0010, 8'd21, 1'b1, 1'b0);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,  1'b1, 1'b1);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,  1'b0, 1'b1);
        cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0,  1'b0, 1'b0);
`ifdef MULT_SHARE_ARB_STATS_EN
        chk("op_count", op_count, 4);
        chk("stall_count", stall_count, 3);
`endif

        // Reset one cycle after a grant: the in-flight product must never be reported.
        do_reset();
        @(posedge clock); #1;
        req = 4'b0001; req_x = 16'h0004; req_y = 16'h0004;
        @(negedge clock);
        chk("mid_gnt", gnt, 1);
        chk("mid_mul_enable", mul_enable, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_mul_enable", mul_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_mul_x", mul_x, 0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b1; req = 4'd0; req_x = 16'd0; req_y = 16'd0;
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clock);
        if (sbq.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d responses outstanding, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
